compare_seq_ctrl: RTL and testbench

Sequential controller that compares two wide unsigned operands using a single shared 4-bit cascadable compare slice. It walks the operands one nibble at a time, LSB nibble first, and feeds each slice result into the cascade input of the next higher nibble. Sits between a requesting datapath (sorter, limit checker) and the magnitude-compare resource, trading latency for area.

---
 rtl/compare_seq_ctrl_pkg.sv | 16 +
 rtl/compare_seq_ctrl_if.sv | 21 ++
 rtl/compare_seq_ctrl_nibble_compare_slice.sv | 21 ++
 rtl/compare_seq_ctrl.sv | 96 +++++++++
 tb/tb_compare_seq_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/compare_seq_ctrl_pkg.sv
// Shared encodings for the nibble-serial magnitude comparator.
// Result vectors are one-hot {gt, lt, eq}.
package compare_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [2:0] CMP_GT   = 3'b100;
   localparam logic [2:0] CMP_LT   = 3'b010;
   localparam logic [2:0] CMP_EQ   = 3'b001;
   localparam logic [2:0] CMP_NONE = 3'b000;

endpackage

// File: rtl/compare_seq_ctrl_if.sv
// Request/result bundle between a requesting datapath and compare_seq_ctrl.
interface compare_seq_ctrl_if #(
   parameter int NIBBLES = 4
);
   logic                   iStart;
   logic [4*NIBBLES-1:0]   iData_a;
   logic [4*NIBBLES-1:0]   iData_b;
   logic                   oBusy;
   logic                   oDone;
   logic [2:0]             oData;

   modport master (
      output iStart, iData_a, iData_b,
      input  oBusy, oDone, oData
   );

   modport slave (
      input  iStart, iData_a, iData_b,
      output oBusy, oDone, oData
   );
endinterface

// File: rtl/compare_seq_ctrl_nibble_compare_slice.sv
// Combinational 4-bit cascadable magnitude compare slice.
// Equal nibbles defer to the lower-order cascade input.
module nibble_compare_slice
   import compare_seq_ctrl_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [2:0] cascIn,
   output logic [2:0] cmpOut
);

   always_comb begin
      cmpOut = cascIn;
      if (a > b) begin
         cmpOut = CMP_GT;
      end else if (a < b) begin
         cmpOut = CMP_LT;
      end
   end

endmodule

// File: rtl/compare_seq_ctrl.sv
// Nibble-serial unsigned compare of two W-bit operands through one shared slice.
// state | meaning
// IDLE  | waiting for iStart
// RUN   | one nibble per cycle, LSB nibble first
// DONE  | oDone pulse; iStart here restarts back-to-back
module compare_seq_ctrl
   import compare_seq_ctrl_pkg::*;
#(
   parameter int NIBBLES = 4
)(
   input  logic              iClk,
   input  logic              iRst_n,
   compare_seq_ctrl_if.slave bus
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t           state, stateNext;
   logic [W-1:0]     opA, opB;
   logic [2:0]       cascade, result, sliceOut;
   logic [IDX_W-1:0] idx;
   logic [3:0]       nibA, nibB;
   logic             load, last;

   assign nibA = 4'(opA >> {idx, 2'b00});
   assign nibB = 4'(opB >> {idx, 2'b00});

   nibble_compare_slice u_slice (
      .a      (nibA),
      .b      (nibB),
      .cascIn (cascade),
      .cmpOut (sliceOut)
   );

   always_comb begin
      stateNext = state;
      load      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.iStart) begin
               load      = 1'b1;
               stateNext = RUN;
            end
         end
         RUN: begin
            if (idx == LAST_IDX) begin
               last      = 1'b1;
               stateNext = DONE;
            end
         end
         DONE: begin
            if (bus.iStart) begin
               load      = 1'b1;
               stateNext = RUN;
            end else begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state   <= IDLE;
         opA     <= '0;
         opB     <= '0;
         cascade <= CMP_EQ;
         idx     <= '0;
         result  <= CMP_NONE;
      end else begin
         state <= stateNext;
         if (load) begin
            opA     <= bus.iData_a;
            opB     <= bus.iData_b;
            cascade <= CMP_EQ;
            idx     <= '0;
         end else if (state == RUN) begin
            cascade <= sliceOut;
            idx     <= idx + IDX_W'(1);
            if (last) begin
               result <= sliceOut;
            end
         end
      end
   end

   // Outputs decode registered state only, so nothing is combinational from inputs.
   assign bus.oBusy = (state == RUN);
   assign bus.oDone = (state == DONE);
   assign bus.oData = result;

endmodule

// File: tb/tb_compare_seq_ctrl.sv
// Directed bench for compare_seq_ctrl with NIBBLES=4 and NIBBLES=1 instances.
module tb_compare_seq_ctrl;

   logic iClk;
   logic iRst_n;
   int   nChecks = 0;
   int   nFail   = 0;
   logic [2:0] last4;
   logic [2:0] last1;

   compare_seq_ctrl_if #(.NIBBLES(4)) bus4 ();
   compare_seq_ctrl_if #(.NIBBLES(1)) bus1 ();

   compare_seq_ctrl #(.NIBBLES(4)) u_dut4 (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .bus    (bus4)
   );

   compare_seq_ctrl #(.NIBBLES(1)) u_dut1 (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .bus    (bus1)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp)
      else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One compare on the 4-nibble instance; optionally disturb inputs mid-RUN.
   task automatic run4(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] exp, input bit disturb);
      @(negedge iClk);
      bus4.iStart  = 1'b1;
      bus4.iData_a = a;
      bus4.iData_b = b;
      @(negedge iClk);
      bus4.iStart = 1'b0;
      for (int j = 0; j < 4; j++) begin
         check({tag, "_busy"}, 32'(bus4.oBusy), 32'd1);
         check({tag, "_nodone"}, 32'(bus4.oDone), 32'd0);
         check({tag, "_hold"}, 32'(bus4.oData), 32'(last4));
         if (disturb && j == 0) begin
            bus4.iStart  = 1'b1;
            bus4.iData_a = ~a;
            bus4.iData_b = ~b;
         end
         if (disturb && j == 2) bus4.iStart = 1'b0;
         @(negedge iClk);
      end
      check({tag, "_done"}, 32'(bus4.oDone), 32'd1);
      check({tag, "_busy_off"}, 32'(bus4.oBusy), 32'd0);
      check({tag, "_data"}, 32'(bus4.oData), 32'(exp));
      last4 = exp;
      @(negedge iClk);
      check({tag, "_pulse"}, 32'(bus4.oDone), 32'd0);
      check({tag, "_keep"}, 32'(bus4.oData), 32'(exp));
   endtask

   task automatic run1(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] exp);
      @(negedge iClk);
      bus1.iStart  = 1'b1;
      bus1.iData_a = a;
      bus1.iData_b = b;
      @(negedge iClk);
      bus1.iStart = 1'b0;
      check({tag, "_busy"}, 32'(bus1.oBusy), 32'd1);
      check({tag, "_hold"}, 32'(bus1.oData), 32'(last1));
      @(negedge iClk);
      check({tag, "_done"}, 32'(bus1.oDone), 32'd1);
      check({tag, "_data"}, 32'(bus1.oData), 32'(exp));
      last1 = exp;
      @(negedge iClk);
      check({tag, "_pulse"}, 32'(bus1.oDone), 32'd0);
   endtask

   initial begin
      iRst_n       = 1'b0;
      bus4.iStart  = 1'b0;
      bus4.iData_a = '0;
      bus4.iData_b = '0;
      bus1.iStart  = 1'b0;
      bus1.iData_a = '0;
      bus1.iData_b = '0;
      last4 = 3'b000;
      last1 = 3'b000;

      #12;
      check("rst_busy", 32'(bus4.oBusy), 32'd0);
      check("rst_done", 32'(bus4.oDone), 32'd0);
      check("rst_data", 32'(bus4.oData), 32'd0);
      check("rst_data1", 32'(bus1.oData), 32'd0);
      @(negedge iClk);
      iRst_n = 1'b1;

      run4("eq", 16'h1234, 16'h1234, 3'b001, 1'b0);
      run4("lt", 16'h1234, 16'h1235, 3'b010, 1'b0);
      run4("gt_msb", 16'h8000, 16'h7FFF, 3'b100, 1'b0);
      run4("lt_msb", 16'h0FFF, 16'h1000, 3'b010, 1'b0);
      run4("latched", 16'h0001, 16'h0010, 3'b010, 1'b1);

      // iStart held high: a result every 5 cycles, starts during RUN ignored.
      @(negedge iClk);
      bus4.iStart  = 1'b1;
      bus4.iData_a = 16'hFFFF;
      bus4.iData_b = 16'h0000;
      for (int k = 0; k < 15; k++) begin
         @(negedge iClk);
         check("b2b_done", 32'(bus4.oDone), (k % 5 == 4) ? 32'd1 : 32'd0);
         check("b2b_busy", 32'(bus4.oBusy), (k % 5 == 4) ? 32'd0 : 32'd1);
         check("b2b_data", 32'(bus4.oData), (k < 4) ? 32'(last4) : 32'b100);
      end
      bus4.iStart = 1'b0;
      last4 = 3'b100;
      @(negedge iClk);
      check("b2b_idle_busy", 32'(bus4.oBusy), 32'd0);
      check("b2b_idle_done", 32'(bus4.oDone), 32'd0);

      // Reset in the third RUN cycle aborts the compare.
      @(negedge iClk);
      bus4.iStart  = 1'b1;
      bus4.iData_a = 16'h0000;
      bus4.iData_b = 16'h0001;
      @(negedge iClk);
      bus4.iStart = 1'b0;
      @(negedge iClk);
      @(negedge iClk);
      check("abort_pre_busy", 32'(bus4.oBusy), 32'd1);
      iRst_n = 1'b0;
      #1;
      check("abort_busy", 32'(bus4.oBusy), 32'd0);
      check("abort_done", 32'(bus4.oDone), 32'd0);
      check("abort_data", 32'(bus4.oData), 32'd0);
      last4 = 3'b000;
      last1 = 3'b000;
      @(negedge iClk);
      @(negedge iClk);
      iRst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge iClk);
         check("abort_nodone", 32'(bus4.oDone), 32'd0);
         check("abort_idle", 32'(bus4.oBusy), 32'd0);
      end
      run4("post_rst", 16'h0002, 16'h0001, 3'b100, 1'b0);

      run1("n1_lt", 4'h3, 4'h9, 3'b010);
      run1("n1_gt", 4'h9, 4'h3, 3'b100);
      run1("n1_eq", 4'h5, 4'h5, 3'b001);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
